// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/result bundle between the issuing controller and alu_seq
// master: drives start/op/in_a/in_b, observes busy/done/rslt/rslt_hi/co/ov/lt/z
// slave : the ALU side of the same signals
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rslt;
    logic [WIDTH-1:0] rslt_hi;
    logic             co;
    logic             ov;
    logic             lt;
    logic             z;

    modport master (
        output start, op, in_a, in_b,
        input  busy, done, rslt, rslt_hi, co, ov, lt, z
    );

    modport slave (
        input  start, op, in_a, in_b,
        output busy, done, rslt, rslt_hi, co, ov, lt, z
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU: single-cycle arithmetic/logic, iterative shifts and shift-add multiply
// clk   : rising-edge clock
// rst_n : asynchronous active-low reset, clears state and every output
// bus   : slave side of alu_seq_if (start/op/in_a/in_b in; busy/done/rslt/rslt_hi/co/ov/lt/z out)
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_seq_if.slave     bus
);
    localparam int CNT_W = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_CMP = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] wrk_q, wrk_d;     // shift register, or multiplicand for MUL
    logic [WIDTH-1:0] mlt_q, mlt_d;     // MUL: multiplier shifting out, product low half shifting in
    logic [WIDTH-1:0] acc_q, acc_d;     // MUL: product high half
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rslt_q, rslt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             co_q, co_d, ov_q, ov_d, lt_q, lt_d, z_q, z_d;
    logic             done_q, done_d;
    logic             busy_q;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]     add_w, sub_w, mul_sum;
    logic [WIDTH-1:0]   shf_nx, mul_acc_nx, mul_lo_nx;
    logic               shf_bit;

    assign shamt   = bus.in_b[SHAMT_W-1:0];
    assign add_w   = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    assign sub_w   = {1'b0, bus.in_a} - {1'b0, bus.in_b};   // MSB is the borrow (a < b unsigned)

    // One shift-add step: add the multiplicand when the multiplier LSB is set, then shift
    // the (WIDTH+1)-bit sum right into the high half, dropping its LSB into the low half.
    assign mul_sum    = {1'b0, acc_q} + (mlt_q[0] ? {1'b0, wrk_q} : '0);
    assign mul_acc_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx  = {mul_sum[0], mlt_q[WIDTH-1:1]};

    always_comb begin
        shf_nx  = {wrk_q[WIDTH-1], wrk_q[WIDTH-1:1]};
        shf_bit = wrk_q[0];
        case (op_q)
            OP_SLL: begin
                shf_nx  = {wrk_q[WIDTH-2:0], 1'b0};
                shf_bit = wrk_q[WIDTH-1];
            end
            OP_SRL: begin
                shf_nx  = {1'b0, wrk_q[WIDTH-1:1]};
                shf_bit = wrk_q[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wrk_d   = wrk_q;
        mlt_d   = mlt_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        rslt_d  = rslt_q;
        hi_d    = hi_q;
        co_d    = co_q;
        ov_d    = ov_q;
        lt_d    = lt_q;
        z_d     = z_q;
        done_d  = 1'b0;

        case (state_q)
            S_RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc_nx;
                    mlt_d = mul_lo_nx;
                end else begin
                    wrk_d = shf_nx;
                end
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    ov_d    = 1'b0;
                    lt_d    = 1'b0;
                    if (op_q == OP_MUL) begin
                        rslt_d = mul_lo_nx;
                        hi_d   = mul_acc_nx;
                        co_d   = (mul_acc_nx != '0);
                        z_d    = ({mul_acc_nx, mul_lo_nx} == '0);
                    end else begin
                        rslt_d = shf_nx;
                        hi_d   = '0;
                        co_d   = shf_bit;
                        z_d    = (shf_nx == '0);
                    end
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE falls back to IDLE when nothing arrives.
                if (!bus.start) begin
                    state_d = S_IDLE;
                end else begin
                    op_d    = bus.op;
                    wrk_d   = bus.in_a;
                    mlt_d   = bus.in_b;
                    acc_d   = '0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    hi_d    = '0;
                    co_d    = 1'b0;
                    ov_d    = 1'b0;
                    lt_d    = 1'b0;
                    z_d     = 1'b0;
                    case (bus.op)
                        OP_ADD: begin
                            rslt_d = add_w[WIDTH-1:0];
                            co_d   = add_w[WIDTH];
                            ov_d   = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                                     (add_w[WIDTH-1] != bus.in_a[WIDTH-1]);
                            z_d    = (add_w[WIDTH-1:0] == '0);
                        end
                        OP_SUB: begin
                            rslt_d = sub_w[WIDTH-1:0];
                            co_d   = sub_w[WIDTH];
                            lt_d   = sub_w[WIDTH];
                            ov_d   = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                                     (sub_w[WIDTH-1] != bus.in_a[WIDTH-1]);
                            z_d    = (sub_w[WIDTH-1:0] == '0);
                        end
                        OP_AND: begin
                            rslt_d = bus.in_a & bus.in_b;
                            z_d    = ((bus.in_a & bus.in_b) == '0);
                        end
                        OP_XOR: begin
                            rslt_d = bus.in_a ^ bus.in_b;
                            z_d    = ((bus.in_a ^ bus.in_b) == '0);
                        end
                        OP_OR: begin
                            rslt_d = bus.in_a | bus.in_b;
                            z_d    = ((bus.in_a | bus.in_b) == '0);
                        end
                        OP_MOV: begin
                            rslt_d = bus.in_b;
                            z_d    = (bus.in_b == '0);
                        end
                        OP_CMP: begin
                            // rslt deliberately keeps its previous value
                            z_d  = (bus.in_a == bus.in_b);
                            lt_d = sub_w[WIDTH];
                        end
                        OP_SLL, OP_SRL, OP_SRA: begin
                            if (shamt == '0) begin
                                rslt_d = bus.in_a;
                                z_d    = (bus.in_a == '0);
                            end else begin
                                state_d = S_RUN;
                                done_d  = 1'b0;
                                cnt_d   = {1'b0, shamt};
                                hi_d    = hi_q;
                                co_d    = co_q;
                                ov_d    = ov_q;
                                lt_d    = lt_q;
                                z_d     = z_q;
                            end
                        end
                        OP_MUL: begin
                            state_d = S_RUN;
                            done_d  = 1'b0;
                            cnt_d   = CNT_MUL;
                            hi_d    = hi_q;
                            co_d    = co_q;
                            ov_d    = ov_q;
                            lt_d    = lt_q;
                            z_d     = z_q;
                        end
                        default: begin
                            rslt_d = '0;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            wrk_q   <= '0;
            mlt_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            rslt_q  <= '0;
            hi_q    <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            lt_q    <= 1'b0;
            z_q     <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wrk_q   <= wrk_d;
            mlt_q   <= mlt_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            rslt_q  <= rslt_d;
            hi_q    <= hi_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
            lt_q    <= lt_d;
            z_q     <= z_d;
            done_q  <= done_d;
            busy_q  <= (state_d == S_RUN);
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rslt    = rslt_q;
    assign bus.rslt_hi = hi_q;
    assign bus.co      = co_q;
    assign bus.ov      = ov_q;
    assign bus.lt      = lt_q;
    assign bus.z       = z_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH=8
module tb_alu_seq;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   lat;
    int   bcnt;
    int   dcnt;

    alu_seq_if #(.WIDTH(8)) bus();

    alu_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {bus.co, bus.ov, bus.lt, bus.z};
    endfunction

    // Issues one request, scrambles the inputs right after acceptance, optionally pokes an
    // ADD start at cycle 'poke' while waiting, and returns accept-to-done latency and busy cycles.
    task automatic exec(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        input int poke, output int l, output int bc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.in_a  = a;
        bus.in_b  = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = ~o;
        bus.in_a  = ~a;
        bus.in_b  = ~b;
        l  = 1;
        bc = 0;
        while (!bus.done && l < 40) begin
            if (bus.busy) bc++;
            bus.start = (l == poke);
            if (l == poke) begin
                bus.op   = 4'd0;
                bus.in_a = 8'h01;
                bus.in_b = 8'h01;
            end
            @(negedge clk);
            l++;
        end
        bus.start = 1'b0;
        chk("done_seen", {31'd0, bus.done}, 32'd1);
        @(negedge clk);
        chk("done_one_pulse", {31'd0, bus.done}, 32'd0);
        chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 4'd0;
        bus.in_a  = 8'h00;
        bus.in_b  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_rslt", {24'd0, bus.rslt}, 32'h0);
        chk("rst_hi", {24'd0, bus.rslt_hi}, 32'h0);
        chk("rst_flags", {28'd0, flags()}, 32'h0);
        chk("rst_busy_done", {30'd0, bus.busy, bus.done}, 32'h0);
        rst_n = 1'b1;

        // ADD 0xF0+0x20: carry out, no signed overflow
        exec(4'd0, 8'hF0, 8'h20, 0, lat, bcnt);
        chk("add_lat", lat, 1);
        chk("add_busy", bcnt, 0);
        chk("add_rslt", {24'd0, bus.rslt}, 32'h10);
        chk("add_flags", {28'd0, flags()}, 32'b1000);

        // SUB then CMP back to back: done stays high, CMP keeps rslt
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd1; bus.in_a = 8'h80; bus.in_b = 8'h01;
        @(negedge clk);
        chk("sub_done", {31'd0, bus.done}, 32'd1);
        chk("sub_rslt", {24'd0, bus.rslt}, 32'h7F);
        chk("sub_flags", {28'd0, flags()}, 32'b0100);
        bus.op = 4'd8; bus.in_a = 8'h05; bus.in_b = 8'h09;
        @(negedge clk);
        bus.start = 1'b0;
        chk("cmp_done", {31'd0, bus.done}, 32'd1);
        chk("cmp_rslt_kept", {24'd0, bus.rslt}, 32'h7F);
        chk("cmp_flags", {28'd0, flags()}, 32'b0010);
        @(negedge clk);
        chk("cmp_done_drop", {31'd0, bus.done}, 32'd0);

        // Shifts
        exec(4'd5, 8'h81, 8'h03, 0, lat, bcnt);
        chk("sll_lat", lat, 4);
        chk("sll_busy", bcnt, 3);
        chk("sll_rslt", {24'd0, bus.rslt}, 32'h08);
        chk("sll_flags", {28'd0, flags()}, 32'b0000);

        exec(4'd7, 8'h90, 8'h02, 0, lat, bcnt);
        chk("sra_lat", lat, 3);
        chk("sra_rslt", {24'd0, bus.rslt}, 32'hE4);
        chk("sra_flags", {28'd0, flags()}, 32'b0000);

        exec(4'd6, 8'h55, 8'h00, 0, lat, bcnt);
        chk("srl0_lat", lat, 1);
        chk("srl0_rslt", {24'd0, bus.rslt}, 32'h55);
        chk("srl0_flags", {28'd0, flags()}, 32'b0000);

        // upper bits of in_b ignored: 0x0B -> shamt 3
        exec(4'd6, 8'h80, 8'h0B, 0, lat, bcnt);
        chk("srl_wrap_lat", lat, 4);
        chk("srl_wrap_rslt", {24'd0, bus.rslt}, 32'h10);

        exec(4'd5, 8'h01, 8'h07, 0, lat, bcnt);
        chk("sll7_lat", lat, 8);
        chk("sll7_rslt", {24'd0, bus.rslt}, 32'h80);

        exec(4'd6, 8'h01, 8'h01, 0, lat, bcnt);
        chk("srl1_rslt", {24'd0, bus.rslt}, 32'h00);
        chk("srl1_flags", {28'd0, flags()}, 32'b1001);

        // MUL 0xFF*0xFF with an ADD start poked mid-run
        exec(4'd10, 8'hFF, 8'hFF, 3, lat, bcnt);
        chk("mul_lat", lat, 9);
        chk("mul_busy", bcnt, 8);
        chk("mul_hi", {24'd0, bus.rslt_hi}, 32'hFE);
        chk("mul_lo", {24'd0, bus.rslt}, 32'h01);
        chk("mul_flags", {28'd0, flags()}, 32'b1000);

        // Operand latching (exec scrambles inputs after acceptance)
        exec(4'd10, 8'h0C, 8'h0A, 0, lat, bcnt);
        chk("mul2_hi", {24'd0, bus.rslt_hi}, 32'h00);
        chk("mul2_lo", {24'd0, bus.rslt}, 32'h78);
        chk("mul2_flags", {28'd0, flags()}, 32'b0000);

        // Reset mid-MUL
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd10; bus.in_a = 8'h33; bus.in_b = 8'h44;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mul3_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_rslt", {24'd0, bus.rslt}, 32'h0);
        chk("arst_hi", {24'd0, bus.rslt_hi}, 32'h0);
        chk("arst_busy_done", {30'd0, bus.busy, bus.done}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        chk("arst_no_done", dcnt, 0);

        exec(4'd0, 8'h01, 8'h01, 0, lat, bcnt);
        chk("add2_lat", lat, 1);
        chk("add2_rslt", {24'd0, bus.rslt}, 32'h02);

        // MUL leaving rslt=0 but non-zero product, then illegal op clears everything
        exec(4'd10, 8'h10, 8'h10, 0, lat, bcnt);
        chk("mul4_hi", {24'd0, bus.rslt_hi}, 32'h01);
        chk("mul4_lo", {24'd0, bus.rslt}, 32'h00);
        chk("mul4_flags", {28'd0, flags()}, 32'b1000);

        exec(4'hF, 8'hFF, 8'hFF, 0, lat, bcnt);
        chk("ill_lat", lat, 1);
        chk("ill_rslt", {24'd0, bus.rslt}, 32'h0);
        chk("ill_hi", {24'd0, bus.rslt_hi}, 32'h0);
        chk("ill_flags", {28'd0, flags()}, 32'b0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
